// File: rtl/if_unit.sv
// rtl/if_unit.sv - instruction fetch stage: PC sequencing plus the IF/ID pipeline register.
// Define IF_DELAY_SLOT_EN to let the branch delay slot execute; by default it is squashed.
module if_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic        ce_o,
  input  logic [31:0] inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  logic        ce_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        squash_slot;

`ifdef IF_DELAY_SLOT_EN
  assign squash_slot = 1'b0;
`else
  assign squash_slot = branch_i;
`endif

  // Redirect targets are word-aligned by dropping their low two bits.
  always_comb begin
    pc_d = pc_q;
    if (!ce_q)
      pc_d = 32'h0000_0000;
    else if (flush_i)
      pc_d = {flush_pc_i[31:2], 2'b00};
    else if (stall_i)
      pc_d = pc_q;
    else if (branch_i)
      pc_d = {branch_target_i[31:2], 2'b00};
    else
      pc_d = pc_q + 32'd4;
  end

  // Flush beats stall; a stalled branch is re-presented by ID later, so it cannot squash here.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush_i) begin
      id_pc_d    = 32'h0000_0000;
      id_inst_d  = 32'h0000_0000;
      id_valid_d = 1'b0;
    end else if (stall_i) begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
    end else if (!ce_q || squash_slot) begin
      id_pc_d    = 32'h0000_0000;
      id_inst_d  = 32'h0000_0000;
      id_valid_d = 1'b0;
    end else begin
      id_pc_d    = pc_q;
      id_inst_d  = inst_i;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q       <= 1'b0;
      pc_q       <= 32'h0000_0000;
      id_pc_q    <= 32'h0000_0000;
      id_inst_q  <= 32'h0000_0000;
      id_valid_q <= 1'b0;
    end else begin
      ce_q       <= 1'b1;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign ce_o       = ce_q;
  assign pc_o       = pc_q;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

endmodule

// File: tb/tb_if_unit.sv
// tb/tb_if_unit.sv - directed bench for if_unit; ROM word at address A is A + 0x11111111.
module tb_if_unit;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  int tests = 0;
  int fails = 0;

  if_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc_o),
    .ce_o            (ce_o),
    .inst_i          (inst_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inst_i = pc_o + 32'h1111_1111;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic valid);
    chk({tag, "_id_pc"}, id_pc_o, pc);
    chk({tag, "_id_inst"}, id_inst_o, inst);
    chk({tag, "_id_valid"}, {31'd0, id_valid_o}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
    branch_i = 1'b0; branch_target_i = '0;

    step(); step(); step();
    chk("rst_ce", {31'd0, ce_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk_id("rst", 32'h0, 32'h0, 1'b0);

    rst = 1'b0;
    step();
    chk("rel1_ce", {31'd0, ce_o}, 32'd1);
    chk("rel1_pc", pc_o, 32'h0);
    chk_id("rel1", 32'h0, 32'h0, 1'b0);
    step();
    chk("rel2_pc", pc_o, 32'h4);
    chk_id("rel2", 32'h0, 32'h1111_1111, 1'b1);
    step();
    chk("rel3_pc", pc_o, 32'h8);
    chk_id("rel3", 32'h4, 32'h1111_1115, 1'b1);

    stall_i = 1'b1;
    step();
    chk("stall1_pc", pc_o, 32'h8);
    chk_id("stall1", 32'h4, 32'h1111_1115, 1'b1);
    step();
    chk("stall2_pc", pc_o, 32'h8);
    chk_id("stall2", 32'h4, 32'h1111_1115, 1'b1);
    stall_i = 1'b0;
    step();
    chk("unstall_pc", pc_o, 32'hC);
    chk_id("unstall", 32'h8, 32'h1111_1119, 1'b1);

    branch_i = 1'b1; branch_target_i = 32'h40;
    step();
    chk("br_pc", pc_o, 32'h40);
`ifdef IF_DELAY_SLOT_EN
    chk_id("br_slot", 32'hC, 32'h1111_111D, 1'b1);
`else
    chk_id("br_slot", 32'h0, 32'h0, 1'b0);
`endif
    branch_i = 1'b0;
    step();
    chk("br_next_pc", pc_o, 32'h44);
    chk_id("br_next", 32'h40, 32'h1111_1151, 1'b1);

    flush_i = 1'b1; stall_i = 1'b1; flush_pc_i = 32'h180;
    step();
    chk("flush_pc", pc_o, 32'h180);
    chk_id("flush", 32'h0, 32'h0, 1'b0);
    flush_i = 1'b0; stall_i = 1'b0;
    step();
    chk("post_flush_pc", pc_o, 32'h184);
    chk_id("post_flush", 32'h180, 32'h1111_1291, 1'b1);

    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFF;
    step();
    chk("flush_top_pc", pc_o, 32'hFFFF_FFFC);
    flush_i = 1'b0;
    step();
    chk("wrap_pc", pc_o, 32'h0);
    chk_id("wrap", 32'hFFFF_FFFC, 32'h1111_110D, 1'b1);

    branch_i = 1'b1; branch_target_i = 32'h43;
    step();
    chk("br_align_pc", pc_o, 32'h40);
`ifdef IF_DELAY_SLOT_EN
    chk_id("br_align", 32'h0, 32'h1111_1111, 1'b1);
`else
    chk_id("br_align", 32'h0, 32'h0, 1'b0);
`endif

    stall_i = 1'b1; branch_target_i = 32'h80;
    step();
    chk("stall_br_pc", pc_o, 32'h40);
`ifdef IF_DELAY_SLOT_EN
    chk_id("stall_br", 32'h0, 32'h1111_1111, 1'b1);
`else
    chk_id("stall_br", 32'h0, 32'h0, 1'b0);
`endif
    stall_i = 1'b0;
    step();
    chk("br_after_stall_pc", pc_o, 32'h80);
    branch_i = 1'b0;
    step();
    chk("seq_pc", pc_o, 32'h84);
    chk_id("seq", 32'h80, 32'h1111_1191, 1'b1);

    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h200;
    rst = 1'b1;
    step();
    chk("midrst_ce", {31'd0, ce_o}, 32'd0);
    chk("midrst_pc", pc_o, 32'h0);
    chk_id("midrst", 32'h0, 32'h0, 1'b0);
    rst = 1'b0; stall_i = 1'b0; branch_i = 1'b0;
    step();
    chk("rerel_ce", {31'd0, ce_o}, 32'd1);
    chk("rerel_pc", pc_o, 32'h0);
    step();
    chk("rerel2_pc", pc_o, 32'h4);
    chk_id("rerel2", 32'h0, 32'h1111_1111, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
